// File: rtl/wb_stage.sv
// MEM/WB pipeline register and write-back datapath: load extraction, result select, x0 suppression.
// Optional retire counter enabled by defining WB_RETIRE_CNT_EN; otherwise RETIRED_WB is tied to 0.
module wb_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic             valid_MEM,
  input  logic             RegWrite_MEM,
  input  logic             MemtoReg_MEM,
  input  logic [2:0]       FUNCT3_MEM,
  input  logic [4:0]       RD_MEM,
  input  logic [XLEN-1:0]  ALU_DATA_MEM,
  input  logic [XLEN-1:0]  READ_DATA_MEM,
  output logic             RegWrite_WB,
  output logic [XLEN-1:0]  ALU_DATA_WB,
  output logic [4:0]       RD_WB,
  output logic             valid_WB,
  output logic [CNT_W-1:0] RETIRED_WB
);

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  logic             vld_p1;
  logic             reg_write_p1;
  logic             mem_to_reg_p1;
  logic [2:0]       funct3_p1;
  logic [4:0]       rd_p1;
  logic [XLEN-1:0]  alu_data_p1;
  logic [XLEN-1:0]  read_data_p1;
  logic [XLEN-1:0]  load_data_p1;

  // Byte/half selection from an aligned word; a[0] is ignored for halves.
  function automatic logic [XLEN-1:0] extract_load(
    input logic [2:0]      f3,
    input logic [1:0]      a,
    input logic [XLEN-1:0] w
  );
    logic signed [7:0]      b;
    logic signed [15:0]     h;
    logic signed [XLEN-1:0] b_sx;
    logic signed [XLEN-1:0] h_sx;
    logic [XLEN-1:0]        res;
    b    = w[{a, 3'b000} +: 8];
    h    = a[1] ? w[31:16] : w[15:0];
    b_sx = XLEN'(b);
    h_sx = XLEN'(h);
    case (f3)
      F3_LB:   res = b_sx;
      F3_LH:   res = h_sx;
      F3_LW:   res = w;
      F3_LBU:  res = {{(XLEN-8){1'b0}}, b};
      F3_LHU:  res = {{(XLEN-16){1'b0}}, h};
      default: res = w;
    endcase
    return res;
  endfunction

  // MEM -> WB boundary
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1        <= 1'b0;
      reg_write_p1  <= 1'b0;
      mem_to_reg_p1 <= 1'b0;
      funct3_p1     <= 3'd0;
      rd_p1         <= 5'd0;
      alu_data_p1   <= '0;
      read_data_p1  <= '0;
    end else if (flush) begin
      vld_p1        <= 1'b0;
      reg_write_p1  <= 1'b0;
      mem_to_reg_p1 <= 1'b0;
      funct3_p1     <= 3'd0;
      rd_p1         <= 5'd0;
      alu_data_p1   <= '0;
      read_data_p1  <= '0;
    end else if (!stall) begin
      vld_p1        <= valid_MEM;
      reg_write_p1  <= RegWrite_MEM;
      mem_to_reg_p1 <= MemtoReg_MEM;
      funct3_p1     <= FUNCT3_MEM;
      rd_p1         <= RD_MEM;
      alu_data_p1   <= ALU_DATA_MEM;
      read_data_p1  <= READ_DATA_MEM;
    end
  end

  always_comb begin
    load_data_p1 = extract_load(funct3_p1, alu_data_p1[1:0], read_data_p1);
  end

  assign ALU_DATA_WB = mem_to_reg_p1 ? load_data_p1 : alu_data_p1;
  assign RD_WB       = rd_p1;
  assign valid_WB    = vld_p1;
  assign RegWrite_WB = reg_write_p1 & vld_p1 & (rd_p1 != 5'd0);

`ifdef WB_RETIRE_CNT_EN
  logic [CNT_W-1:0] retired_p1;

  // An instruction retires when its WB slot is vacated (not held by stall).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retired_p1 <= '0;
    end else if (vld_p1 && (flush || !stall)) begin
      retired_p1 <= retired_p1 + CNT_W'(1);
    end
  end

  assign RETIRED_WB = retired_p1;
`else
  assign RETIRED_WB = '0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage; retire-counter checks follow WB_RETIRE_CNT_EN.
module tb_wb_stage;
  localparam int XLEN  = 32;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             stall = 1'b0;
  logic             flush = 1'b0;
  logic             valid_MEM = 1'b0;
  logic             RegWrite_MEM = 1'b0;
  logic             MemtoReg_MEM = 1'b0;
  logic [2:0]       FUNCT3_MEM = 3'd0;
  logic [4:0]       RD_MEM = 5'd0;
  logic [XLEN-1:0]  ALU_DATA_MEM = '0;
  logic [XLEN-1:0]  READ_DATA_MEM = '0;
  logic             RegWrite_WB;
  logic [XLEN-1:0]  ALU_DATA_WB;
  logic [4:0]       RD_WB;
  logic             valid_WB;
  logic [CNT_W-1:0] RETIRED_WB;

  int total = 0;
  int bad = 0;

  wb_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .valid_MEM(valid_MEM), .RegWrite_MEM(RegWrite_MEM), .MemtoReg_MEM(MemtoReg_MEM),
    .FUNCT3_MEM(FUNCT3_MEM), .RD_MEM(RD_MEM), .ALU_DATA_MEM(ALU_DATA_MEM),
    .READ_DATA_MEM(READ_DATA_MEM), .RegWrite_WB(RegWrite_WB), .ALU_DATA_WB(ALU_DATA_WB),
    .RD_WB(RD_WB), .valid_WB(valid_WB), .RETIRED_WB(RETIRED_WB)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic rw, input logic m2r, input logic [2:0] f3,
                       input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] rdata);
    valid_MEM = v; RegWrite_MEM = rw; MemtoReg_MEM = m2r; FUNCT3_MEM = f3;
    RD_MEM = rd; ALU_DATA_MEM = alu; READ_DATA_MEM = rdata;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    #2;
    total++;
    if ({valid_WB, RegWrite_WB, RD_WB, ALU_DATA_WB} !== 39'd0) begin
      bad++; $display("FAIL reset_outputs got=%h exp=0", {valid_WB, RegWrite_WB, RD_WB, ALU_DATA_WB});
    end
    total++;
    if (RETIRED_WB !== '0) begin bad++; $display("FAIL reset_retired got=%0d exp=0", RETIRED_WB); end
    step();
    reset = 1'b0;
  endtask

  task automatic test_alu_op();
    drive(1, 1, 0, 3'd0, 5'd5, 32'h1234_5678, 32'h0);
    step();
    total++;
    if (RegWrite_WB !== 1'b1 || RD_WB !== 5'd5 || valid_WB !== 1'b1) begin
      bad++; $display("FAIL alu_ctrl got rw=%0b rd=%0d v=%0b exp rw=1 rd=5 v=1", RegWrite_WB, RD_WB, valid_WB);
    end
    total++;
    if (ALU_DATA_WB !== 32'h1234_5678) begin
      bad++; $display("FAIL alu_data got=%h exp=12345678", ALU_DATA_WB);
    end
  endtask

  task automatic test_loads();
    logic [2:0]  f3s  [8];
    logic [31:0] alus [8];
    logic [31:0] exps [8];
    f3s  = '{3'b000, 3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b001, 3'b011};
    alus = '{32'h1000_0001, 32'h1000_0003, 32'h1000_0003, 32'h1000_0002,
             32'h1000_0000, 32'h1000_0000, 32'h1000_0003, 32'h1000_0002};
    exps = '{32'h0000_007F, 32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF,
             32'h0000_7F01, 32'h80FF_7F01, 32'hFFFF_80FF, 32'h80FF_7F01};
    for (int i = 0; i < 8; i++) begin
      drive(1, 1, 1, f3s[i], 5'd10, alus[i], 32'h80FF_7F01);
      step();
      total++;
      if (ALU_DATA_WB !== exps[i] || RegWrite_WB !== 1'b1) begin
        bad++; $display("FAIL load_%0d f3=%b got=%h rw=%0b exp=%h rw=1", i, f3s[i], ALU_DATA_WB, RegWrite_WB, exps[i]);
      end
    end
  endtask

  task automatic test_x0_invalid();
    drive(1, 1, 0, 3'd0, 5'd0, 32'hDEAD_BEEF, 32'h0);
    step();
    total++;
    if (RegWrite_WB !== 1'b0 || ALU_DATA_WB !== 32'hDEAD_BEEF || valid_WB !== 1'b1) begin
      bad++; $display("FAIL x0_write got rw=%0b data=%h v=%0b exp rw=0 data=deadbeef v=1", RegWrite_WB, ALU_DATA_WB, valid_WB);
    end
    drive(0, 1, 0, 3'd0, 5'd3, 32'h0000_0033, 32'h0);
    step();
    total++;
    if (RegWrite_WB !== 1'b0 || valid_WB !== 1'b0 || RD_WB !== 5'd3) begin
      bad++; $display("FAIL invalid_slot got rw=%0b v=%0b rd=%0d exp rw=0 v=0 rd=3", RegWrite_WB, valid_WB, RD_WB);
    end
  endtask

  task automatic test_stall_flush();
    drive(1, 1, 0, 3'd0, 5'd7, 32'h0000_0777, 32'h0);
    step();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, 3'd0, 5'd9, 32'h0000_0999 + i, 32'h0);
      step();
      total++;
      if (RD_WB !== 5'd7 || RegWrite_WB !== 1'b1 || ALU_DATA_WB !== 32'h0000_0777) begin
        bad++; $display("FAIL stall_hold_%0d got rd=%0d rw=%0b data=%h exp rd=7 rw=1 data=777", i, RD_WB, RegWrite_WB, ALU_DATA_WB);
      end
    end
    flush = 1'b1;
    step();
    total++;
    if (valid_WB !== 1'b0 || RegWrite_WB !== 1'b0 || RD_WB !== 5'd0 || ALU_DATA_WB !== 32'h0) begin
      bad++; $display("FAIL flush_over_stall got v=%0b rw=%0b rd=%0d data=%h exp all 0", valid_WB, RegWrite_WB, RD_WB, ALU_DATA_WB);
    end
    flush = 1'b0; stall = 1'b0;
    drive(1, 1, 0, 3'd0, 5'd12, 32'h0000_0C0C, 32'h0);
    step();
    total++;
    if (RD_WB !== 5'd12 || RegWrite_WB !== 1'b1 || ALU_DATA_WB !== 32'h0000_0C0C) begin
      bad++; $display("FAIL after_flush got rd=%0d rw=%0b data=%h exp rd=12 rw=1 data=c0c", RD_WB, RegWrite_WB, ALU_DATA_WB);
    end
  endtask

  task automatic test_async_reset();
    drive(1, 1, 0, 3'd0, 5'd4, 32'h0000_0044, 32'h0);
    step();
    total++;
    if (RegWrite_WB !== 1'b1) begin bad++; $display("FAIL pre_reset_rw got=%0b exp=1", RegWrite_WB); end
    #2 reset = 1'b1;
    #1;
    total++;
    if (RegWrite_WB !== 1'b0 || valid_WB !== 1'b0 || RD_WB !== 5'd0 || ALU_DATA_WB !== 32'h0) begin
      bad++; $display("FAIL async_reset got rw=%0b v=%0b rd=%0d data=%h exp all 0", RegWrite_WB, valid_WB, RD_WB, ALU_DATA_WB);
    end
    reset = 1'b0;
    drive(1, 1, 0, 3'd0, 5'd6, 32'h0000_0066, 32'h0);
    step();
    total++;
    if (RD_WB !== 5'd6 || RegWrite_WB !== 1'b1 || ALU_DATA_WB !== 32'h0000_0066) begin
      bad++; $display("FAIL post_reset got rd=%0d rw=%0b data=%h exp rd=6 rw=1 data=66", RD_WB, RegWrite_WB, ALU_DATA_WB);
    end
  endtask

  task automatic test_retire_cnt();
    logic [CNT_W-1:0] exp10;
    logic [CNT_W-1:0] exp17;
`ifdef WB_RETIRE_CNT_EN
    exp10 = 4'd10;
    exp17 = 4'd1;
`else
    exp10 = 4'd0;
    exp17 = 4'd0;
`endif
    drive(0, 0, 0, 3'd0, 5'd0, 32'h0, 32'h0);
    #1 reset = 1'b1;
    #1 reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i == 3 || i == 6) begin
        stall = 1'b1;
        drive(1, 1, 0, 3'd0, 5'd31, 32'hBAD0_0000, 32'h0);
        step();
        stall = 1'b0;
      end
      drive(1, 1, 0, 3'd0, 5'(i + 1), 32'(i), 32'h0);
      step();
    end
    drive(0, 0, 0, 3'd0, 5'd0, 32'h0, 32'h0);
    step();
    total++;
    if (RETIRED_WB !== exp10) begin bad++; $display("FAIL retire_10 got=%0d exp=%0d", RETIRED_WB, exp10); end
    for (int i = 0; i < 7; i++) begin
      drive(1, 0, 0, 3'd0, 5'd0, 32'h0, 32'h0);
      step();
    end
    drive(0, 0, 0, 3'd0, 5'd0, 32'h0, 32'h0);
    step();
    total++;
    if (RETIRED_WB !== exp17) begin bad++; $display("FAIL retire_wrap got=%0d exp=%0d", RETIRED_WB, exp17); end
  endtask

  initial begin
    test_reset();
    test_alu_op();
    test_loads();
    test_x0_invalid();
    test_stall_flush();
    test_async_reset();
    test_retire_cnt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
